// File: rtl/rsp_s2_prep_accum_if.sv
// Handshake bundle between the stage-2 prep multiplier side and the coherent integrator.
// The master drives the aligned product stream; the slave returns group sums and status.
interface rsp_s2_prep_accum_if #(
  parameter int unsigned P_width   = 15,
  parameter int unsigned ACC_width = 24,
  parameter int unsigned N_width   = 10
) ();
  logic                 IN_VALID;
  logic                 IN_SOF;
  logic [P_width-1:0]   PRODUCT;
  logic [N_width-1:0]   ACC_LEN;
  logic                 OUT_VALID;
  logic [ACC_width-1:0] OUT_DATA;
  logic                 OUT_SAT;
  logic                 OUT_SOF;
  logic                 DROP;
  logic                 BUSY;

  modport master (
    output IN_VALID, IN_SOF, PRODUCT, ACC_LEN,
    input  OUT_VALID, OUT_DATA, OUT_SAT, OUT_SOF, DROP, BUSY
  );

  modport slave (
    input  IN_VALID, IN_SOF, PRODUCT, ACC_LEN,
    output OUT_VALID, OUT_DATA, OUT_SAT, OUT_SOF, DROP, BUSY
  );
endinterface

// File: rtl/rsp_s2_prep_accum.sv
// Coherent integrator: sums ACC_LEN multiplier products per group into a saturating signed
// result, with valid/SOF qualifiers delayed internally to line up with PRODUCT.
module rsp_s2_prep_accum #(
  parameter int unsigned DELAY     = 2,
  parameter int unsigned P_width   = 15,
  parameter int unsigned ACC_width = 24,
  parameter int unsigned N_width   = 10,
  parameter int unsigned SIGNED    = 1
) (
  input logic               CLK,
  input logic               RST,
  rsp_s2_prep_accum_if.slave bus
);
  localparam int unsigned AW1 = ACC_width + 1;
  localparam logic [ACC_width-1:0] AccMax = {1'b0, {(ACC_width-1){1'b1}}};
  localparam logic [ACC_width-1:0] AccMin = {1'b1, {(ACC_width-1){1'b0}}};
  localparam logic [N_width:0]     CntOne = {{N_width{1'b0}}, 1'b1};
  localparam logic [N_width-1:0]   LenOne = {{(N_width-1){1'b0}}, 1'b1};

  typedef enum logic {StIdle, StAcc} state_e;

  state_e               r_state;
  logic [DELAY-1:0]     r_v_sr;
  logic [DELAY-1:0]     r_s_sr;
  logic [ACC_width-1:0] r_acc;
  logic [N_width-1:0]   r_cnt;
  logic [N_width-1:0]   r_len;
  logic                 r_sat;
  logic                 r_sof;
  logic                 r_out_valid;
  logic [ACC_width-1:0] r_out_data;
  logic                 r_out_sat;
  logic                 r_out_sof;
  logic                 r_drop;

  logic                 w_v_d;
  logic                 w_s_d;
  logic                 w_start;
  logic [N_width-1:0]   w_len_in;
  logic [N_width-1:0]   w_len;
  logic [N_width:0]     w_cnt_nxt;
  logic                 w_last;
  logic [AW1-1:0]       w_base;
  logic [AW1-1:0]       w_ext;
  logic [AW1-1:0]       w_sum;
  logic                 w_ovf;
  logic [ACC_width-1:0] w_sat_val;
  logic                 w_sat_any;
  logic                 w_sof_flag;

  always_comb begin
    w_v_d    = r_v_sr[DELAY-1];
    w_s_d    = r_s_sr[DELAY-1];
    // An SOF sample always opens a fresh group, discarding any partial one.
    w_start  = (r_state == StIdle) || w_s_d;
    w_len_in = (bus.ACC_LEN == '0) ? LenOne : bus.ACC_LEN;
    w_len    = w_start ? w_len_in : r_len;
    w_cnt_nxt = w_start ? CntOne : ({1'b0, r_cnt} + CntOne);
    w_last   = (w_cnt_nxt == {1'b0, w_len});
    w_base   = w_start ? '0 : {r_acc[ACC_width-1], r_acc};
    if (SIGNED != 0) begin
      w_ext = {{(AW1-P_width){bus.PRODUCT[P_width-1]}}, bus.PRODUCT};
    end else begin
      w_ext = {{(AW1-P_width){1'b0}}, bus.PRODUCT};
    end
    w_sum = w_base + w_ext;
    // Top two bits disagree only when the sum left the ACC_width signed range.
    w_ovf = w_sum[ACC_width] ^ w_sum[ACC_width-1];
    if (w_ovf) begin
      w_sat_val = w_sum[ACC_width] ? AccMin : AccMax;
    end else begin
      w_sat_val = w_sum[ACC_width-1:0];
    end
    w_sat_any  = w_ovf | (!w_start & r_sat);
    w_sof_flag = w_start ? w_s_d : r_sof;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= StIdle;
      r_v_sr      <= '0;
      r_s_sr      <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_len       <= LenOne;
      r_sat       <= 1'b0;
      r_sof       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
      r_out_sof   <= 1'b0;
      r_drop      <= 1'b0;
    end else begin
      r_v_sr[0] <= bus.IN_VALID;
      r_s_sr[0] <= bus.IN_VALID & bus.IN_SOF;
      for (int i = 1; i < int'(DELAY); i++) begin
        r_v_sr[i] <= r_v_sr[i-1];
        r_s_sr[i] <= r_s_sr[i-1];
      end
      r_out_valid <= 1'b0;
      r_drop      <= 1'b0;
      if (w_v_d) begin
        if ((r_state == StAcc) && w_s_d) begin
          r_drop <= 1'b1;
        end
        if (w_start) begin
          r_len <= w_len_in;
          r_sof <= w_s_d;
        end
        if (w_last) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_sat_val;
          r_out_sat   <= w_sat_any;
          r_out_sof   <= w_sof_flag;
          r_acc       <= '0;
          r_cnt       <= '0;
          r_sat       <= 1'b0;
          r_state     <= StIdle;
        end else begin
          r_acc   <= w_sat_val;
          r_cnt   <= w_cnt_nxt[N_width-1:0];
          r_sat   <= w_sat_any;
          r_state <= StAcc;
        end
      end
    end
  end

  assign bus.OUT_VALID = r_out_valid;
  assign bus.OUT_DATA  = r_out_data;
  assign bus.OUT_SAT   = r_out_sat;
  assign bus.OUT_SOF   = r_out_sof;
  assign bus.DROP      = r_drop;
  assign bus.BUSY      = (r_state == StAcc);
endmodule
